// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions: sequencer state encoding and instruction field constants.
package rv_pipe_pkg;

  typedef enum logic [0:0] {
    IDLE,
    MD_BUSY
  } md_state_e;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [6:0]  OP_LOAD      = 7'b0000011;
  localparam logic [6:0]  OP_REG       = 7'b0110011;
  localparam logic [6:0]  FUNCT7_MULDIV = 7'b0000001;

endpackage

// File: rtl/muldiv_sequencer.sv
// Occupancy sequencer for the multi-cycle MUL/DIV unit in EX: start/done pulses and
// front-end hold for exactly LATENCY cycles counted from the start cycle.
module muldiv_sequencer #(
  parameter int unsigned MUL_LATENCY = 3,
  parameter int unsigned DIV_LATENCY = 33,
  parameter int unsigned CNT_W       = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic is_div,
  output logic start,
  output logic done,
  output logic hold,
  output logic busy
);
  import rv_pipe_pkg::*;

  localparam logic [CNT_W-1:0] MulInit = CNT_W'(MUL_LATENCY - 1);
  localparam logic [CNT_W-1:0] DivInit = CNT_W'(DIV_LATENCY - 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_init;

  assign cnt_init = is_div ? DivInit : MulInit;
  assign busy     = (state_q == MD_BUSY);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start   = 1'b0;
    done    = 1'b0;
    hold    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          start = 1'b1;
          // Single-cycle op completes in its start cycle and never stalls.
          if (cnt_init == '0) begin
            done = 1'b1;
          end else begin
            hold    = 1'b1;
            cnt_d   = cnt_init;
            state_d = MD_BUSY;
          end
        end
      end
      MD_BUSY: begin
        hold  = 1'b1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, redirect and MUL/DIV holds.
// Optional HAZARD_PERF_CNT_EN adds saturating per-event cycle counters.
module pipeline_hazard_controller #(
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned MUL_LATENCY = 3,
  parameter int unsigned DIV_LATENCY = 33,
  parameter int unsigned CNT_W       = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_muldiv,
  input  logic                  ex_is_div,
  input  logic                  ex_redirect,
  output logic                  pc_hold,
  output logic                  ifid_hold,
  output logic                  idex_hold,
  output logic                  idex_bubble,
  output logic                  ifid_flush,
  output logic                  muldiv_start,
  output logic                  muldiv_done
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]           perf_loaduse_cnt,
  output logic [31:0]           perf_flush_cnt,
  output logic [31:0]           perf_md_stall_cnt
`endif
);

  logic md_start, md_done, md_hold, md_busy;
  logic rs1_hit, rs2_hit;
  logic load_use, redirect, md_stall;

  muldiv_sequencer #(
    .MUL_LATENCY(MUL_LATENCY),
    .DIV_LATENCY(DIV_LATENCY),
    .CNT_W      (CNT_W)
  ) u_muldiv_sequencer (
    .clk   (clk),
    .reset (reset),
    .req   (ex_muldiv),
    .is_div(ex_is_div),
    .start (md_start),
    .done  (md_done),
    .hold  (md_hold),
    .busy  (md_busy)
  );

  assign rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);

  // Redirect wins over load-use: the ID instruction is wrong-path. Both are moot while EX
  // holds an M-op. Reset forces every output low even though these paths are combinational.
  assign redirect = ex_redirect && !md_busy && !reset;
  assign load_use = ex_mem_read && (ex_rd != '0) && (rs1_hit || rs2_hit) &&
                    !ex_redirect && !md_busy && !reset;
  assign md_stall = md_hold && !reset;

  assign pc_hold      = load_use || md_stall;
  assign ifid_hold    = load_use || md_stall;
  assign idex_hold    = md_stall;
  assign idex_bubble  = load_use || redirect;
  assign ifid_flush   = redirect;
  assign muldiv_start = md_start && !reset;
  assign muldiv_done  = md_done && !reset;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_loaduse_cnt  <= '0;
      perf_flush_cnt    <= '0;
      perf_md_stall_cnt <= '0;
    end else begin
      if (load_use && (perf_loaduse_cnt != '1)) perf_loaduse_cnt <= perf_loaduse_cnt + 32'd1;
      if (redirect && (perf_flush_cnt != '1)) perf_flush_cnt <= perf_flush_cnt + 32'd1;
      if (md_stall && (perf_md_stall_cnt != '1)) perf_md_stall_cnt <= perf_md_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed self-checking bench for pipeline_hazard_controller (default parameters).
module tb_pipeline_hazard_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_muldiv, ex_is_div, ex_redirect;
  logic       pc_hold, ifid_hold, idex_hold, idex_bubble, ifid_flush, muldiv_start, muldiv_done;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_loaduse_cnt, perf_flush_cnt, perf_md_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // {pc_hold, ifid_hold, idex_hold, idex_bubble, ifid_flush, muldiv_start, muldiv_done}
  logic [6:0] outs;
  assign outs = {pc_hold, ifid_hold, idex_hold, idex_bubble, ifid_flush, muldiv_start,
                 muldiv_done};

  always #5 clk = ~clk;

  pipeline_hazard_controller dut (
    .clk         (clk),
    .reset       (reset),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .ex_muldiv   (ex_muldiv),
    .ex_is_div   (ex_is_div),
    .ex_redirect (ex_redirect),
    .pc_hold     (pc_hold),
    .ifid_hold   (ifid_hold),
    .idex_hold   (idex_hold),
    .idex_bubble (idex_bubble),
    .ifid_flush  (ifid_flush),
    .muldiv_start(muldiv_start),
    .muldiv_done (muldiv_done)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .perf_loaduse_cnt (perf_loaduse_cnt),
    .perf_flush_cnt   (perf_flush_cnt),
    .perf_md_stall_cnt(perf_md_stall_cnt)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; ex_mem_read = 0;
    ex_muldiv = 0; ex_is_div = 0; ex_redirect = 0;
  endtask

  // One cycle: drive at negedge, sample combinational outputs 2 time units later.
  task automatic vec(input string tag, input logic [4:0] rs1, input logic u1,
                     input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                     input logic mr, input logic redir, input logic [6:0] exp);
    @(negedge clk);
    drive_idle();
    id_rs1 = rs1; id_uses_rs1 = u1; id_rs2 = rs2; id_uses_rs2 = u2;
    ex_rd = rd; ex_mem_read = mr; ex_redirect = redir;
    #2 check_val(tag, {25'b0, outs}, {25'b0, exp});
  endtask

  // Holds the M-op in EX for ncyc cycles of an n-cycle op; optional redirect at redir_at.
  task automatic md_run(input string tag, input logic div, input int n, input int ncyc,
                        input int redir_at);
    logic [6:0] exp;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      drive_idle();
      ex_muldiv = 1; ex_is_div = div; ex_redirect = (i == redir_at);
      exp = {5'b11100, (i == 0), (i == n - 1)};
      #2 check_val(tag, {25'b0, outs}, {25'b0, exp});
    end
  endtask

  initial begin
    drive_idle();
    reset = 1;
    // Load-use inputs present during reset must not leak to the outputs.
    ex_mem_read = 1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1;
    #2 check_val("reset_outs", {25'b0, outs}, 32'd0);
    @(negedge clk);
    drive_idle();
    reset = 0;
    #2 check_val("idle_after_reset", {25'b0, outs}, 32'd0);

    vec("loaduse_rs2",    5'd0, 0, 5'd5, 1, 5'd5, 1, 0, 7'b1101000);
    vec("loaduse_done",   5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 7'b0000000);
    vec("loaduse_rd0",    5'd0, 0, 5'd0, 1, 5'd0, 1, 0, 7'b0000000);
    vec("loaduse_rs1",    5'd7, 1, 5'd0, 0, 5'd7, 1, 0, 7'b1101000);
    vec("rs1_not_used",   5'd7, 0, 5'd0, 0, 5'd7, 1, 0, 7'b0000000);
    vec("not_a_load",     5'd9, 1, 5'd9, 1, 5'd9, 0, 0, 7'b0000000);
    vec("redir_beats_lu", 5'd0, 0, 5'd5, 1, 5'd5, 1, 1, 7'b0001100);

    md_run("mul", 0, 3, 3, -1);
    vec("mul_release", 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 7'b0000000);

    md_run("div_redir", 1, 33, 33, 10);
    vec("div_release", 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 7'b0000000);

`ifdef HAZARD_PERF_CNT_EN
    check_val("perf_loaduse", perf_loaduse_cnt, 32'd2);
    check_val("perf_flush", perf_flush_cnt, 32'd1);
    check_val("perf_md_stall", perf_md_stall_cnt, 32'd36);
`endif

    // Reset in cycle 15 of a DIV: outputs drop at once and no done follows.
    md_run("div_pre_reset", 1, 33, 15, -1);
    @(negedge clk);
    reset = 1;
    #2 check_val("mid_div_reset", {25'b0, outs}, 32'd0);
    @(negedge clk);
    drive_idle();
    reset = 0;
    #2 check_val("post_reset_idle", {25'b0, outs}, 32'd0);
    vec("no_late_done", 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 7'b0000000);
    md_run("mul_after_reset", 0, 3, 3, -1);
    vec("mul2_release", 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 7'b0000000);

    // Back-to-back MULs from a clean reset so the stall counter starts at zero.
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    md_run("b2b_mul_a", 0, 3, 3, -1);
    md_run("b2b_mul_b", 0, 3, 3, -1);
    vec("b2b_release", 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 7'b0000000);
`ifdef HAZARD_PERF_CNT_EN
    check_val("perf_b2b_stall", perf_md_stall_cnt, 32'd6);
    check_val("perf_b2b_flush", perf_flush_cnt, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
Central stall/flush sequencer for the 5-stage RV32IM pipeline. It sits beside the Decode-stage ControlUnit and takes register indices and control bits from the ID and EX stages. It drives the hold, bubble and flush enables of the PC, IF/ID and ID/EX registers. It detects load-use hazards and redirects from taken branches and jumps. It also sequences the multi-cycle MUL/DIV unit in EX, freezing the front end until the unit finishes.

Parameters:
REG_ADDR_W, 5, register index width
MUL_LATENCY, 3, EX cycles a MUL/MULH* op occupies (min 1)
DIV_LATENCY, 33, EX cycles a DIV/REM op occupies (min 1)
CNT_W, 6, width of the busy counter (must hold DIV_LATENCY-1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
id_rs1  in  REG_ADDR_W  rs1 of instruction in ID
id_rs2  in  REG_ADDR_W  rs2 of instruction in ID
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_rd  in  REG_ADDR_W  rd of instruction in EX
ex_mem_read  in  1  EX instruction is a load (MemRead)
ex_muldiv  in  1  EX instruction is an M-extension op
ex_is_div  in  1  M-op in EX is DIV/DIVU/REM/REMU (else MUL class)
ex_redirect  in  1  taken branch, JAL or JALR resolved in EX
pc_hold  out  1  PC keeps its value
ifid_hold  out  1  IF/ID keeps its value
idex_hold  out  1  ID/EX keeps its value
idex_bubble  out  1  ID/EX loads a NOP (all control bits 0)
ifid_flush  out  1  IF/ID loads a NOP
muldiv_start  out  1  one-cycle pulse to start the MUL/DIV unit
muldiv_done  out  1  one-cycle pulse in the final busy cycle; result valid

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, counter=0. All outputs are 0 during and after reset, before the first valid input.
- State machine states: IDLE, MD_BUSY.
- IDLE, load-use hazard:
  - Condition: ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
  - Response: pc_hold=ifid_hold=idex_bubble=1 in the same cycle (combinational).
  - Lasts exactly 1 cycle, because the load then advances.
- IDLE, redirect: ex_redirect=1 gives ifid_flush=1 and idex_bubble=1 in the same cycle.
  - Redirect has priority over load-use: the ID instruction is wrong-path, so no holds are asserted.
- IDLE, M-op: ex_muldiv=1 gives muldiv_start=1 for the same cycle.
  - Counter loads (ex_is_div ? DIV_LATENCY : MUL_LATENCY)-1.
  - If that value is 0: muldiv_done=1 in the same cycle, with no holds.
  - Otherwise: pc_hold=ifid_hold=idex_hold=1 and next state is MD_BUSY.
- MD_BUSY:
  - Every cycle: pc_hold=ifid_hold=idex_hold=1 and counter decrements.
  - When counter==1: muldiv_done=1, holds still asserted, next state IDLE.
  - Total occupancy is exactly LATENCY cycles, counting from the start cycle.
- No overlap or simultaneous events:
  - ex_redirect and load-use are ignored while in MD_BUSY, because EX holds the M-op.
  - A load-use hazard against an M-op in EX cannot arise, because ex_mem_read=0.
- Back-to-back M-ops: the second op enters EX on the cycle after done and starts immediately. There are no idle gap cycles beyond the pipeline advance.
- Reset asserted mid-MD_BUSY: immediate return to IDLE. No muldiv_done pulse is produced.
- Counter arithmetic is unsigned CNT_W-bit and never wraps; a decrement below 0 is impossible by construction.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: adds outputs perf_loaduse_cnt[31:0], perf_flush_cnt[31:0] and perf_md_stall_cnt[31:0].
  - Each counts cycles with, respectively: load-use hold, redirect flush, or M-op hold asserted.
  - Each saturates at 32'hFFFFFFFF and clears on reset.
- Undefined: these ports and their registers are absent; all other behaviour is identical.

Decomposition:
- Shared package rv_pipe_pkg:
  - state enum IDLE/MD_BUSY;
  - NOP instruction constant 32'h00000013;
  - opcode constants OP_LOAD=7'b0000011 and OP_REG=7'b0110011;
  - funct7 M-extension constant 7'b0000001.
- Natural sub-module: muldiv_sequencer, containing the FSM, counter, start/done pulses and busy signal. Load-use and redirect logic stay in the top-level block.

Test Plan:
- Load-use: EX={ex_mem_read=1, ex_rd=5}, ID={id_rs2=5, id_uses_rs2=1} -> pc_hold=ifid_hold=idex_bubble=1 for 1 cycle. Same stimulus with ex_rd=0 -> no hold.
- Redirect beats load-use: load-use condition true and ex_redirect=1 in the same cycle -> ifid_flush=idex_bubble=1, pc_hold=0.
- MUL (MUL_LATENCY=3): ex_muldiv=1, ex_is_div=0 -> muldiv_start at cycle 0; holds=1 for cycles 0-2; muldiv_done at cycle 2; holds=0 at cycle 3.
- DIV: ex_is_div=1 -> holds asserted for exactly 33 cycles; done on the 33rd. ex_redirect pulsed at cycle 10 -> no flush.
- Reset mid-DIV: assert reset at cycle 15 -> all outputs 0 immediately, no done. A new MUL after reset is released takes 3 cycles.
- Back-to-back MUL, MUL -> two start pulses 3 cycles apart, with done pulses at cycle 2 and cycle 5. With HAZARD_PERF_CNT_EN defined, perf_md_stall_cnt=6 afterwards.
